// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the packet arbiter feeding the shared async_fifo.
// State encoding and width helpers used by RTL and readers alike.
package fifo_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic int idw_f(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w_f(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// Round-robin pick: first set request after the last grant, with wrap.
// Purely combinational.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          any
);

   function automatic logic [IW-1:0] wrap_add(
      input logic [IW-1:0] base,
      input int            off
   );
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return IW'(s);
   endfunction

   // Walk from farthest to nearest so the nearest candidate wins.
   always_comb begin
      idx = last;
      any = 1'b0;
      for (int i = N; i >= 1; i--) begin
         if (req[wrap_add(last, i)]) begin
            idx = wrap_add(last, i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_arbiter.sv
// Packet-level round-robin arbiter writing NCH channels into one async_fifo.
// A grant is held for a whole packet; MAX_LEN forces release and flags an error.
module fifo_arbiter
   import fifo_arbiter_pkg::*;
#(
   parameter  int NCH     = 4,
   parameter  int WIDTH   = 8,
   parameter  int MAX_LEN = 32,
   localparam int IDW     = idw_f(NCH),
   localparam int CW      = cnt_w_f(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     req_valid,
   input  logic [NCH-1:0]     req_last,
   input  logic [NCH*WIDTH-1:0] req_data,
   output logic [NCH-1:0]     req_ready,
   output logic               fifo_shift,
   output logic [WIDTH-1:0]   fifo_data,
   input  logic               fifo_full,
   output logic [IDW-1:0]     grant_id,
   output logic               busy,
   output logic               err_overlong
);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;

   logic [IDW-1:0] pick_idx;
   logic           pick_any;

   rr_pick #(
      .N  (NCH),
      .IW (IDW)
   ) u_pick (
      .req  (req_valid),
      .last (grant_q),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= IDW'(NCH - 1);
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Handshake is gated by rst_n so a reset mid-packet writes nothing more.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      req_ready  = '0;
      fifo_shift = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            req_ready[grant_q] = !fifo_full && rst_n;
            fifo_shift = req_valid[grant_q] && req_ready[grant_q];
            if (fifo_shift) begin
               cnt_d = cnt_q + CW'(1);
               if (req_last[grant_q]) begin
                  state_d = IDLE;
               end else if (cnt_q + CW'(1) == CW'(MAX_LEN)) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_data    = req_data[int'(grant_q)*WIDTH +: WIDTH];
   assign grant_id     = grant_q;
   assign busy         = (state_q == BUSY);
   assign err_overlong = err_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a queue model of the shared FIFO.
module tb_fifo_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_last, req_ready;
   logic [31:0] req_data;
   logic        fifo_shift, fifo_full, busy, err_overlong;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;

   logic [3:0]  v4, l4, ready4;
   logic [31:0] d4;
   logic        shift4, busy4, err4;
   logic [7:0]  data4;
   logic [1:0]  grant4;

   always #5 clk = ~clk;

   fifo_arbiter #(.NCH(4), .WIDTH(8), .MAX_LEN(32)) u_dut (
      .clk (clk), .rst_n (rst_n),
      .req_valid (req_valid), .req_last (req_last),
      .req_data (req_data), .req_ready (req_ready),
      .fifo_shift (fifo_shift), .fifo_data (fifo_data),
      .fifo_full (fifo_full), .grant_id (grant_id),
      .busy (busy), .err_overlong (err_overlong)
   );

   fifo_arbiter #(.NCH(4), .WIDTH(8), .MAX_LEN(4)) u_dut4 (
      .clk (clk), .rst_n (rst_n),
      .req_valid (v4), .req_last (l4),
      .req_data (d4), .req_ready (ready4),
      .fifo_shift (shift4), .fifo_data (data4),
      .fifo_full (1'b0), .grant_id (grant4),
      .busy (busy4), .err_overlong (err4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  fq [$];
   logic [7:0]  rd_log [$];
   logic [15:0] wl [$];
   logic [8:0]  srcq [4][$];
   logic        rd_en = 1'b0;
   logic        shift_seen;
   logic [3:0]  acc;

   // FIFO model: 32 deep, random-pop reader.
   initial fifo_full = 1'b0;
   always @(posedge clk) begin
      if (fifo_shift) begin
         wl.push_back({6'd0, grant_id, fifo_data});
         if (fq.size() < 32) fq.push_back(fifo_data);
      end
      if (rd_en && fq.size() > 0 && $urandom_range(0, 1) == 1)
         rd_log.push_back(fq.pop_front());
      fifo_full <= (fq.size() == 32);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() > 0) begin
            req_valid[i] = 1'b1;
            req_last[i]  = srcq[i][0][8];
            req_data[i*8 +: 8] = srcq[i][0][7:0];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      #1;
      acc = req_valid & req_ready;
      shift_seen = fifo_shift;
      @(posedge clk);
      for (int i = 0; i < 4; i++)
         if (acc[i]) void'(srcq[i].pop_front());
      @(negedge clk);
   endtask

   function automatic int src_left();
      int s = 0;
      for (int i = 0; i < 4; i++) s += srcq[i].size();
      return s;
   endfunction

   task automatic drain();
      int n = 0;
      rd_en = 1'b1;
      while (fq.size() != 0 && n < 500) begin
         cyc();
         n++;
      end
      chk("drain", fq.size(), 0);
   endtask

   initial begin
      int n, shifts, bad;
      rst_n = 1'b0;
      req_valid = '0; req_last = '0; req_data = 32'hA0B0C0D0;
      v4 = '0; l4 = '0; d4 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_shift", fifo_shift, 0);
      chk("rst_err", err_overlong, 0);
      chk("rst_grant", grant_id, 3);
      chk("rst_data", fifo_data, 8'hA0);
      @(negedge clk);

      // ch1 alone, 3-word packet
      wl.delete(); rd_log.delete(); rd_en = 1'b1;
      srcq[1].push_back({1'b0, 8'h10});
      srcq[1].push_back({1'b0, 8'h11});
      srcq[1].push_back({1'b1, 8'h12});
      cyc();
      chk("t1_arb_shift", shift_seen, 0);
      chk("t1_busy", busy, 1);
      chk("t1_grant", grant_id, 1);
      shifts = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (shift_seen) shifts++;
      end
      chk("t1_busy_drop", busy, 0);
      cyc(); cyc();
      if (shift_seen) shifts++;
      chk("t1_shifts", shifts, 3);
      chk("t1_wl_n", wl.size(), 3);
      drain();
      chk("t1_rd_n", rd_log.size(), 3);
      if (rd_log.size() == 3) begin
         chk("t1_rd0", rd_log[0], 8'h10);
         chk("t1_rd1", rd_log[1], 8'h11);
         chk("t1_rd2", rd_log[2], 8'h12);
      end

      // all channels, 2-word tagged packets, ch0 twice
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      wl.delete();
      for (int i = 0; i < 4; i++) begin
         srcq[i].push_back({1'b0, 8'(i*16)});
         srcq[i].push_back({1'b1, 8'(i*16 + 1)});
      end
      srcq[0].push_back({1'b0, 8'h02});
      srcq[0].push_back({1'b1, 8'h03});
      n = 0;
      do begin
         cyc();
         n++;
      end while ((src_left() != 0 || busy) && n < 100);
      chk("t2_cycles", n, 15);
      chk("t2_wl_n", wl.size(), 10);
      if (wl.size() == 10) begin
         chk("t2_w0", wl[0], 16'h000);
         chk("t2_w1", wl[1], 16'h001);
         chk("t2_w2", wl[2], 16'h110);
         chk("t2_w3", wl[3], 16'h111);
         chk("t2_w4", wl[4], 16'h220);
         chk("t2_w5", wl[5], 16'h221);
         chk("t2_w6", wl[6], 16'h330);
         chk("t2_w7", wl[7], 16'h331);
         chk("t2_w8", wl[8], 16'h002);
         chk("t2_w9", wl[9], 16'h003);
      end
      drain();

      // backpressure: reader stalled, ch0 streams 40 words
      rd_en = 1'b0; wl.delete(); rd_log.delete();
      for (int k = 0; k < 40; k++)
         srcq[0].push_back({(k % 8) == 7, 8'(k)});
      n = 0;
      while (!fifo_full && n < 200) begin
         cyc();
         n++;
      end
      chk("t3_full", fifo_full, 1);
      chk("t3_fq_n", fq.size(), 32);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t3_ready_full", req_ready[0], 0);
         chk("t3_shift_full", shift_seen, 0);
      end
      chk("t3_wl_n", wl.size(), 32);
      rd_en = 1'b1;
      n = 0;
      while ((src_left() != 0 || busy || fq.size() != 0) && n < 1000) begin
         cyc();
         n++;
      end
      chk("t3_rd_n", rd_log.size(), 40);
      bad = 0;
      foreach (rd_log[k])
         if (rd_log[k] !== 8'(k)) bad++;
      chk("t3_order", bad, 0);
      chk("t3_err", err_overlong, 0);

      // MAX_LEN=4 instance: ch2 overlong, then ch3
      v4 = 4'b0100; l4 = '0; d4 = 32'h0020_0000;
      #1;
      chk("t4_idle", busy4, 0);
      @(negedge clk);
      chk("t4_grant2", grant4, 2);
      chk("t4_busy", busy4, 1);
      v4 = 4'b1100;
      shifts = 0;
      for (int k = 0; k < 4; k++) begin
         d4[23:16] = 8'(32 + k);
         #1;
         if (shift4 && data4 == 8'(32 + k)) shifts++;
         @(negedge clk);
      end
      chk("t4_shifts", shifts, 4);
      chk("t4_release", busy4, 0);
      chk("t4_err", err4, 1);
      chk("t4_idle_shift", shift4, 0);
      @(negedge clk);
      chk("t4_grant3", grant4, 3);
      chk("t4_busy3", busy4, 1);
      chk("t4_err_sticky", err4, 1);
      v4 = '0;

      // reset during word 2 of a 5-word ch1 packet
      wl.delete();
      for (int k = 0; k < 5; k++)
         srcq[1].push_back({k == 4, 8'(8'h60 + k)});
      cyc();
      chk("t5_grant1", grant_id, 1);
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("t5_rst_shift", shift_seen, 0);
      chk("t5_wl_n", wl.size(), 1);
      chk("t5_busy", busy, 0);
      chk("t5_err", err_overlong, 0);
      srcq[0].push_back({1'b1, 8'h55});
      cyc();
      chk("t5_grant0", grant_id, 0);
      chk("t5_busy0", busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
